multi_debounce: RTL and testbench

- Parametrised N-channel debouncer for mechanical buttons/switches: synchronises each raw input, filters bounce with a per-channel stability counter, and produces debounced levels, one-cycle rise/fall strobes, long-press detection and per-channel press counters.
- Sits between board pins and LED/control logic; successor to the single-channel fixed-width debounce block, with channel count, polarity, filter length and hold detection all parametrised.

---
 rtl/multi_debounce_pkg.sv | 17 +
 rtl/debounce_channel.sv | 147 ++++++++++++++
 rtl/multi_debounce.sv | 59 +++++
 tb/tb_multi_debounce.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_debounce_pkg.sv
// Shared types and elaboration helpers for the multi-channel debouncer.
// Channel FSM state encoding is fixed so it can be observed on a debugger.
package multi_debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_e;

  // True when len fits an unsigned counter of width bw and is at least lo.
  function automatic bit len_ok(int len, int bw, int lo);
    return (len >= lo) && (len <= ((1 << bw) - 1));
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: synchroniser, stability/hold FSM, strobes and a
// wrapping press counter.
//
//   state        | meaning
//   RELEASED     | debounced level 0, waiting for a pressed sample
//   PRESS_WAIT   | pressed samples seen, counting toward STABLE_LEN
//   PRESSED      | debounced level 1, hold counter running toward HOLD_LEN
//   RELEASE_WAIT | released samples seen, counting toward STABLE_LEN
module debounce_channel
  import multi_debounce_pkg::*;
#(
  parameter int CNT_BW     = 11,
  parameter int STABLE_LEN = 1000,
  parameter int HOLD_LEN   = 2000,
  parameter int PCNT_BW    = 8,
  parameter int ACTIVE_LOW = 0
) (
  input  logic               clk,
  input  logic               aclr,
  input  logic               raw,
  input  logic               cnt_clr,
  output logic               level,
  output logic               rise,
  output logic               fall,
  output logic               long_pulse,
  output logic               long_held,
  output logic [PCNT_BW-1:0] press_cnt
);

  localparam logic              INACTIVE  = (ACTIVE_LOW != 0);
  localparam logic [CNT_BW-1:0] STABLE_TC = CNT_BW'(STABLE_LEN - 1);
  localparam logic [CNT_BW-1:0] HOLD_TC   = CNT_BW'((HOLD_LEN > 0) ? HOLD_LEN - 1 : 0);
  localparam bit                HOLD_EN   = (HOLD_LEN > 0);

  logic              sync1, sync2, s;
  deb_state_e        state_q, state_d;
  logic [CNT_BW-1:0] cnt_q, cnt_d;
  logic              level_d, rise_d, fall_d, long_pulse_d, long_held_d;

  // The synchroniser carries the raw pin level; polarity is folded in after it.
  always_ff @(posedge clk) begin
    if (aclr) begin
      sync1 <= INACTIVE;
      sync2 <= INACTIVE;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  assign s = sync2 ^ INACTIVE;

  always_ff @(posedge clk) begin
    if (aclr) begin
      state_q    <= RELEASED;
      cnt_q      <= '0;
      level      <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      long_pulse <= 1'b0;
      long_held  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      level      <= level_d;
      rise       <= rise_d;
      fall       <= fall_d;
      long_pulse <= long_pulse_d;
      long_held  <= long_held_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    level_d      = level;
    rise_d       = 1'b0;
    fall_d       = 1'b0;
    long_pulse_d = 1'b0;
    long_held_d  = long_held;
    case (state_q)
      RELEASED: begin
        if (s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_TC) begin
          state_d = PRESSED;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else if (HOLD_EN && !long_held) begin
          // Counter parks at the threshold once the long press is flagged.
          if (cnt_q == HOLD_TC) begin
            long_pulse_d = 1'b1;
            long_held_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_TC) begin
          state_d     = RELEASED;
          cnt_d       = '0;
          level_d     = 1'b0;
          fall_d      = 1'b1;
          long_held_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  // A clear coinciding with a rise keeps that press.
  always_ff @(posedge clk) begin
    if (aclr) begin
      press_cnt <= '0;
    end else if (cnt_clr) begin
      press_cnt <= PCNT_BW'(rise);
    end else begin
      press_cnt <= press_cnt + PCNT_BW'(rise);
    end
  end

endmodule

// File: rtl/multi_debounce.sv
// N-channel button debouncer: replicates debounce_channel per input bit,
// packs the per-channel outputs and merges edge strobes into any_event.
module multi_debounce
  import multi_debounce_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int CNT_BW     = 11,
  parameter int STABLE_LEN = 1000,
  parameter int HOLD_LEN   = 2000,
  parameter int PCNT_BW    = 8,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                        clk,
  input  logic                        aclr,
  input  logic [CHANNELS-1:0]         data,
  input  logic                        cnt_clr,
  output logic [CHANNELS-1:0]         level,
  output logic [CHANNELS-1:0]         rise,
  output logic [CHANNELS-1:0]         fall,
  output logic [CHANNELS-1:0]         long_pulse,
  output logic [CHANNELS-1:0]         long_held,
  output logic [CHANNELS*PCNT_BW-1:0] press_cnt,
  output logic                        any_event
);

  if (!len_ok(STABLE_LEN, CNT_BW, 1)) begin : g_bad_stable_len
    $error("multi_debounce: STABLE_LEN out of range for CNT_BW");
  end
  if (!len_ok(HOLD_LEN, CNT_BW, 0)) begin : g_bad_hold_len
    $error("multi_debounce: HOLD_LEN out of range for CNT_BW");
  end
  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
    $error("multi_debounce: CHANNELS must be 1..16");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .CNT_BW     (CNT_BW),
      .STABLE_LEN (STABLE_LEN),
      .HOLD_LEN   (HOLD_LEN),
      .PCNT_BW    (PCNT_BW),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_ch (
      .clk        (clk),
      .aclr       (aclr),
      .raw        (data[i]),
      .cnt_clr    (cnt_clr),
      .level      (level[i]),
      .rise       (rise[i]),
      .fall       (fall[i]),
      .long_pulse (long_pulse[i]),
      .long_held  (long_held[i]),
      .press_cnt  (press_cnt[i*PCNT_BW +: PCNT_BW])
    );
  end

  assign any_event = |{rise, fall};

endmodule

// File: tb/tb_multi_debounce.sv
// Directed bench for multi_debounce: an active-high instance (u_a) and an
// active-low instance (u_b) sharing clock, reset and counter clear.
module tb_multi_debounce;

  localparam int CH = 2;
  localparam int CB = 4;
  localparam int SL = 4;
  localparam int HL = 10;
  localparam int PB = 4;

  logic clk = 1'b0;
  logic aclr, cnt_clr;
  logic [CH-1:0] raw_a, raw_b;

  logic [CH-1:0]    lvl_a, rise_a, fall_a, lp_a, lh_a;
  logic [CH*PB-1:0] pc_a;
  logic             any_a;
  logic [CH-1:0]    lvl_b, rise_b, fall_b, lp_b, lh_b;
  logic [CH*PB-1:0] pc_b;
  logic             any_b;

  int checks = 0;
  int passed = 0;
  int al_strobes = 0;
  bit mon_en = 1'b0;

  multi_debounce #(.CHANNELS(CH), .CNT_BW(CB), .STABLE_LEN(SL), .HOLD_LEN(HL),
                   .PCNT_BW(PB), .ACTIVE_LOW(0)) u_a (
    .clk(clk), .aclr(aclr), .data(raw_a), .cnt_clr(cnt_clr),
    .level(lvl_a), .rise(rise_a), .fall(fall_a), .long_pulse(lp_a),
    .long_held(lh_a), .press_cnt(pc_a), .any_event(any_a));

  multi_debounce #(.CHANNELS(CH), .CNT_BW(CB), .STABLE_LEN(SL), .HOLD_LEN(HL),
                   .PCNT_BW(PB), .ACTIVE_LOW(1)) u_b (
    .clk(clk), .aclr(aclr), .data(raw_b), .cnt_clr(cnt_clr),
    .level(lvl_b), .rise(rise_b), .fall(fall_b), .long_pulse(lp_b),
    .long_held(lh_b), .press_cnt(pc_b), .any_event(any_b));

  always #5 clk = ~clk;

  // Strobes seen on the active-low instance while its pins sit idle high.
  always @(negedge clk) begin
    if (mon_en && (rise_b !== 2'b00 || fall_b !== 2'b00 || lp_b !== 2'b00)) al_strobes++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_all();
    raw_a = 2'b00;
    repeat (12) tick();
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if ({lvl_a, rise_a, fall_a, lp_a, lh_a, pc_a, any_a} !== '0)
      $display("FAIL reset_outputs_a: got %h expected 0", {lvl_a, rise_a, fall_a, lp_a, lh_a, pc_a, any_a});
    else passed++;
    checks++;
    if ({lvl_b, rise_b, fall_b, lp_b, lh_b, pc_b, any_b} !== '0)
      $display("FAIL reset_outputs_b: got %h expected 0", {lvl_b, rise_b, fall_b, lp_b, lh_b, pc_b, any_b});
    else passed++;
    aclr = 1'b0;
    mon_en = 1'b1;
    begin
      int ev;
      ev = 0;
      for (int j = 0; j < 10; j++) begin
        tick();
        if (any_a !== 1'b0 || lvl_a !== 2'b00) ev++;
      end
      checks++;
      if (ev != 0) $display("FAIL reset_exit_quiet: got %0d events expected 0", ev);
      else passed++;
    end
  endtask

  task automatic test_bounce();
    logic [15:0] pat;
    int rise_at, nrise, n1;
    pat = 16'b1010010111000011;
    rise_at = -1; nrise = 0; n1 = 0;
    for (int j = 0; j < 30; j++) begin
      raw_a[0] = (j < 16) ? pat[15-j] : 1'b1;
      tick();
      if (rise_a[0] === 1'b1) begin
        nrise++;
        if (rise_at < 0) rise_at = j;
      end
      if (rise_a[1] !== 1'b0 || lvl_a[1] !== 1'b0) n1++;
    end
    checks++;
    if (nrise != 1) $display("FAIL bounce_rise_count: got %0d expected 1", nrise); else passed++;
    checks++;
    if (rise_at != 20) $display("FAIL bounce_rise_edge: got %0d expected 20", rise_at); else passed++;
    checks++;
    if (lvl_a[0] !== 1'b1) $display("FAIL bounce_level: got %b expected 1", lvl_a[0]); else passed++;
    checks++;
    if (pc_a[3:0] !== 4'd1) $display("FAIL bounce_press_cnt: got %0d expected 1", pc_a[3:0]); else passed++;
    checks++;
    if (n1 != 0) $display("FAIL bounce_ch1_quiet: got %0d expected 0", n1); else passed++;
    release_all();
  endtask

  task automatic test_clean_latency();
    int rise_at, any_at, nany;
    logic lvl6;
    rise_at = -1; any_at = -1; nany = 0; lvl6 = 1'bx;
    raw_a[1] = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      tick();
      if (j == 6) lvl6 = lvl_a[1];
      if (rise_a[1] === 1'b1 && rise_at < 0) rise_at = j;
      if (any_a === 1'b1) begin
        nany++;
        if (any_at < 0) any_at = j;
      end
    end
    checks++;
    if (rise_at != 7) $display("FAIL latency_rise_edge: got %0d expected 7", rise_at); else passed++;
    checks++;
    if (lvl6 !== 1'b0) $display("FAIL latency_level_early: got %b expected 0", lvl6); else passed++;
    checks++;
    if (lvl_a[1] !== 1'b1) $display("FAIL latency_level: got %b expected 1", lvl_a[1]); else passed++;
    checks++;
    if (nany != 1 || any_at != 7)
      $display("FAIL latency_any_event: got %0d cycles at %0d expected 1 at 7", nany, any_at);
    else passed++;
    release_all();
  endtask

  task automatic test_long_press();
    int rise_at, lp_at, nlp, fall_at;
    logic lh6, lh_fall;
    rise_at = -1; lp_at = -1; nlp = 0; fall_at = -1; lh6 = 1'bx; lh_fall = 1'bx;
    raw_a[0] = 1'b1;
    for (int j = 1; j <= 12 && rise_at < 0; j++) begin
      tick();
      if (rise_a[0] === 1'b1) rise_at = j;
    end
    checks++;
    if (rise_at != 7) $display("FAIL long_rise_edge: got %0d expected 7", rise_at); else passed++;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (lp_a[0] === 1'b1) begin
        nlp++;
        if (lp_at < 0) lp_at = t;
      end
    end
    checks++;
    if (lp_at != 10) $display("FAIL long_pulse_edge: got %0d expected 10", lp_at); else passed++;
    checks++;
    if (nlp != 1) $display("FAIL long_pulse_width: got %0d expected 1", nlp); else passed++;
    checks++;
    if (lh_a[0] !== 1'b1) $display("FAIL long_held_set: got %b expected 1", lh_a[0]); else passed++;
    raw_a[0] = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      tick();
      if (j == 6) lh6 = lh_a[0];
      if (fall_a[0] === 1'b1 && fall_at < 0) begin
        fall_at = j;
        lh_fall = lh_a[0];
      end
    end
    checks++;
    if (fall_at != 7) $display("FAIL long_fall_edge: got %0d expected 7", fall_at); else passed++;
    checks++;
    if (lh6 !== 1'b1) $display("FAIL long_held_before_fall: got %b expected 1", lh6); else passed++;
    checks++;
    if (lh_fall !== 1'b0) $display("FAIL long_held_at_fall: got %b expected 0", lh_fall); else passed++;
  endtask

  task automatic press_ch0();
    raw_a[0] = 1'b1;
    repeat (8) tick();
    raw_a[0] = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_counter();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++;
    if (pc_a !== 8'h00) $display("FAIL cnt_initial_clear: got %h expected 00", pc_a); else passed++;
    for (int p = 1; p <= 16; p++) begin
      press_ch0();
      if (p == 15) begin
        checks++;
        if (pc_a[3:0] !== 4'd15) $display("FAIL cnt_fifteen: got %0d expected 15", pc_a[3:0]); else passed++;
      end
    end
    checks++;
    if (pc_a[3:0] !== 4'd0) $display("FAIL cnt_wrap: got %0d expected 0", pc_a[3:0]); else passed++;
    repeat (3) press_ch0();
    checks++;
    if (pc_a[3:0] !== 4'd3) $display("FAIL cnt_three: got %0d expected 3", pc_a[3:0]); else passed++;
    raw_a[0] = 1'b1;
    repeat (7) tick();
    checks++;
    if (rise_a[0] !== 1'b1) $display("FAIL cnt_clr_rise_present: got %b expected 1", rise_a[0]); else passed++;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++;
    if (pc_a !== 8'h01) $display("FAIL cnt_clr_with_rise: got %h expected 01", pc_a); else passed++;
    raw_a[0] = 1'b0;
    repeat (12) tick();
    checks++;
    if (pc_a[3:0] !== 4'd1) $display("FAIL cnt_hold_after_release: got %0d expected 1", pc_a[3:0]); else passed++;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++;
    if (pc_a[3:0] !== 4'd0) $display("FAIL cnt_clr_alone: got %0d expected 0", pc_a[3:0]); else passed++;
  endtask

  task automatic test_reset_mid_bounce();
    int r0, r1;
    r0 = -1; r1 = -1;
    raw_a[1] = 1'b1;
    repeat (8) tick();
    checks++;
    if (lvl_a[1] !== 1'b1 || pc_a[7:4] !== 4'd1)
      $display("FAIL midrst_pre_state: got level %b cnt %0d expected 1 and 1", lvl_a[1], pc_a[7:4]);
    else passed++;
    raw_a[0] = 1'b1;
    repeat (5) tick();
    aclr = 1'b1;
    tick();
    aclr = 1'b0;
    checks++;
    if ({lvl_a, rise_a, fall_a, lp_a, lh_a, pc_a, any_a} !== '0)
      $display("FAIL midrst_outputs: got %h expected 0", {lvl_a, rise_a, fall_a, lp_a, lh_a, pc_a, any_a});
    else passed++;
    for (int j = 1; j <= 12; j++) begin
      tick();
      if (rise_a[0] === 1'b1 && r0 < 0) r0 = j;
      if (rise_a[1] === 1'b1 && r1 < 0) r1 = j;
    end
    checks++;
    if (r0 != 7) $display("FAIL midrst_rise_ch0: got %0d expected 7", r0); else passed++;
    checks++;
    if (r1 != 7) $display("FAIL midrst_rise_ch1: got %0d expected 7", r1); else passed++;
    release_all();
  endtask

  task automatic test_active_low();
    int r, f;
    r = -1; f = -1;
    checks++;
    if (al_strobes != 0) $display("FAIL al_idle_strobes: got %0d expected 0", al_strobes); else passed++;
    raw_b[0] = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      tick();
      if (rise_b[0] === 1'b1 && r < 0) r = j;
    end
    checks++;
    if (r != 7) $display("FAIL al_rise_edge: got %0d expected 7", r); else passed++;
    checks++;
    if (lvl_b !== 2'b01) $display("FAIL al_level_pressed: got %b expected 01", lvl_b); else passed++;
    checks++;
    if (pc_b[3:0] !== 4'd1) $display("FAIL al_press_cnt: got %0d expected 1", pc_b[3:0]); else passed++;
    raw_b[0] = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      tick();
      if (fall_b[0] === 1'b1 && f < 0) f = j;
    end
    checks++;
    if (f != 7) $display("FAIL al_fall_edge: got %0d expected 7", f); else passed++;
    checks++;
    if (lvl_b !== 2'b00) $display("FAIL al_level_released: got %b expected 00", lvl_b); else passed++;
  endtask

  initial begin
    aclr    = 1'b1;
    cnt_clr = 1'b0;
    raw_a   = 2'b00;
    raw_b   = 2'b11;
    test_reset();
    test_bounce();
    test_clean_latency();
    test_long_press();
    test_counter();
    test_reset_mid_bounce();
    test_active_low();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
